// File: rtl/vga_game_pkg.sv
// Shared constants and state encoding for the VGA target game blocks.
package vga_game_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned GRID_DIM = 4;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    SHOW = 2'd1,
    COOL = 2'd2
  } state_t;

endpackage

// File: rtl/target_box_cmp.sv
// Combinational point-in-square test; the caller supplies any register stage.
module target_box_cmp #(
  parameter int unsigned SIZE = 32
) (
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       inside_c
);

  // 11-bit upper bounds so x+SIZE cannot wrap near the screen edge
  logic [10:0] x_end;
  logic [10:0] y_end;

  assign x_end    = {1'b0, x} + 11'(SIZE);
  assign y_end    = {1'b0, y} + 11'(SIZE);
  assign inside_c = (hcount >= x) && ({1'b0, hcount} < x_end) &&
                    (vcount >= y) && ({1'b0, vcount} < y_end);

endmodule

// File: rtl/rand_target_spawner.sv
// Spawns a square target in a 4x4 grid cell chosen by rand_val, times it in nanos wraps.
// Optional: RAND_TARGET_NO_REPEAT_EN bumps a repeated cell to (cell+1) mod 16.
module rand_target_spawner
  import vga_game_pkg::*;
#(
  parameter int unsigned CELL_W   = H_ACTIVE / GRID_DIM,
  parameter int unsigned CELL_H   = V_ACTIVE / GRID_DIM,
  parameter int unsigned TGT_SIZE = 32,
  parameter int unsigned LIFETIME = 3,
  parameter int unsigned COOLDOWN = 1
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [3:0]  rand_val,
  input  logic [27:0] nanos,
  input  logic        hit,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        video_on,
  output logic        target_on,
  output logic [9:0]  target_x,
  output logic [9:0]  target_y,
  output logic [7:0]  score,
  output logic [7:0]  misses,
  output logic        busy
);

  localparam int unsigned X_OFF = (CELL_W - TGT_SIZE) / 2;
  localparam int unsigned Y_OFF = (CELL_H - TGT_SIZE) / 2;

  state_t      state;
  logic [27:0] nanos_q;
  logic [3:0]  rand_q;
  logic [3:0]  tick_cnt;
  logic [3:0]  next_cnt_c;
  logic        tick_c;
  logic        new_rand_c;
  logic [3:0]  cell_c;
  logic [9:0]  spawn_x_c;
  logic [9:0]  spawn_y_c;
  logic        inside_c;

  assign tick_c     = (nanos == 28'd0) && (nanos_q != 28'd0);
  assign new_rand_c = (rand_val != rand_q);
  assign next_cnt_c = tick_cnt + 4'd1;

`ifdef RAND_TARGET_NO_REPEAT_EN
  logic [3:0] prev_cell;

  assign cell_c = (rand_val == prev_cell) ? rand_val + 4'd1 : rand_val;

  // Remember the cell of each spawned target
  always_ff @(posedge CLK) begin
    if (!reset) begin
      prev_cell <= 4'd0;
    end else if (state == WAIT && new_rand_c) begin
      prev_cell <= cell_c;
    end
  end
`else
  assign cell_c = rand_val;
`endif

  // row = cell[3:2], col = cell[1:0]
  assign spawn_x_c = 10'(cell_c[1:0]) * 10'(CELL_W) + 10'(X_OFF);
  assign spawn_y_c = 10'(cell_c[3:2]) * 10'(CELL_H) + 10'(Y_OFF);

  target_box_cmp #(.SIZE(TGT_SIZE)) u_box (
    .hcount   (hcount),
    .vcount   (vcount),
    .x        (target_x),
    .y        (target_y),
    .inside_c (inside_c)
  );

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state     <= WAIT;
      nanos_q   <= 28'd0;
      rand_q    <= rand_val;
      tick_cnt  <= 4'd0;
      target_on <= 1'b0;
      target_x  <= 10'd0;
      target_y  <= 10'd0;
      score     <= 8'd0;
      misses    <= 8'd0;
      busy      <= 1'b0;
    end else begin
      nanos_q   <= nanos;
      rand_q    <= rand_val;
      target_on <= video_on && (state == SHOW) && inside_c;
      case (state)
        WAIT: begin
          if (new_rand_c) begin
            target_x <= spawn_x_c;
            target_y <= spawn_y_c;
            tick_cnt <= 4'd0;
            busy     <= 1'b1;
            state    <= SHOW;
          end
        end
        SHOW: begin
          // A hit on the final tick counts as a hit, not a miss
          if (hit) begin
            if (score != 8'hFF) score <= score + 8'd1;
            tick_cnt <= 4'd0;
            busy     <= 1'b0;
            state    <= COOL;
          end else if (tick_c) begin
            if (next_cnt_c == 4'(LIFETIME)) begin
              if (misses != 8'hFF) misses <= misses + 8'd1;
              tick_cnt <= 4'd0;
              busy     <= 1'b0;
              state    <= COOL;
            end else begin
              tick_cnt <= next_cnt_c;
            end
          end
        end
        COOL: begin
          if (COOLDOWN == 0) begin
            state <= WAIT;
          end else if (tick_c) begin
            if (next_cnt_c == 4'(COOLDOWN)) begin
              tick_cnt <= 4'd0;
              state    <= WAIT;
            end else begin
              tick_cnt <= next_cnt_c;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= WAIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rand_target_spawner.sv
// Directed self-checking bench for rand_target_spawner.
module tb_rand_target_spawner;

  logic        CLK = 1'b0;
  logic        reset;
  logic [3:0]  rand_val;
  logic [27:0] nanos;
  logic        hit;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        video_on;
  logic        target_on;
  logic [9:0]  target_x;
  logic [9:0]  target_y;
  logic [7:0]  score;
  logic [7:0]  misses;
  logic        busy;

  int checks = 0;
  int errors = 0;

  rand_target_spawner dut (
    .CLK       (CLK),
    .reset     (reset),
    .rand_val  (rand_val),
    .nanos     (nanos),
    .hit       (hit),
    .hcount    (hcount),
    .vcount    (vcount),
    .video_on  (video_on),
    .target_on (target_on),
    .target_x  (target_x),
    .target_y  (target_y),
    .score     (score),
    .misses    (misses),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One nanos wrap: nonzero then zero; tick is registered at the second edge
  task automatic do_tick();
    nanos = 28'd5;
    step();
    nanos = 28'd0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0; rand_val = 4'd0; nanos = 28'd0; hit = 1'b0;
    hcount = 10'd0; vcount = 10'd0; video_on = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    checks++;
    if ({target_on, target_x, target_y, score, misses, busy} !== 38'd0) begin
      errors++;
      $display("FAIL reset_outputs: got on=%0b x=%0d y=%0d score=%0d misses=%0d busy=%0b, want all 0",
               target_on, target_x, target_y, score, misses, busy);
    end
    hit = 1'b1;
    step();
    hit = 1'b0;
    for (int i = 0; i < 100; i++) step();
    checks++;
    if (busy !== 1'b0 || score !== 8'd0) begin
      errors++;
      $display("FAIL idle_no_spawn: got busy=%0b score=%0d, want busy=0 score=0", busy, score);
    end
  endtask

  task automatic test_spawn();
    rand_val = 4'd5;
    step();
    checks++;
    if (busy !== 1'b1 || target_x !== 10'd224 || target_y !== 10'd164) begin
      errors++;
      $display("FAIL spawn_cell5: got busy=%0b x=%0d y=%0d, want 1 224 164", busy, target_x, target_y);
    end
    hcount = 10'd224; vcount = 10'd164; video_on = 1'b1;
    step();
    checks++;
    if (target_on !== 1'b1) begin
      errors++;
      $display("FAIL on_top_left: got %0b, want 1", target_on);
    end
    hcount = 10'd255; vcount = 10'd195;
    step();
    checks++;
    if (target_on !== 1'b1) begin
      errors++;
      $display("FAIL on_bottom_right: got %0b, want 1", target_on);
    end
    hcount = 10'd256;
    step();
    checks++;
    if (target_on !== 1'b0) begin
      errors++;
      $display("FAIL off_right_edge: got %0b, want 0", target_on);
    end
    hcount = 10'd230; vcount = 10'd170; video_on = 1'b0;
    step();
    checks++;
    if (target_on !== 1'b0) begin
      errors++;
      $display("FAIL off_video_blank: got %0b, want 0", target_on);
    end
  endtask

  task automatic test_hit();
    hit = 1'b1;
    step();
    hit = 1'b0;
    checks++;
    if (score !== 8'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hit_score: got score=%0d busy=%0b, want 1 0", score, busy);
    end
    video_on = 1'b1;
    step();
    checks++;
    if (target_on !== 1'b0) begin
      errors++;
      $display("FAIL cool_dark: got %0b, want 0", target_on);
    end
    // Change during COOL is consumed; WAIT needs a fresh change afterwards
    rand_val = 4'd9;
    step();
    do_tick();
    step(); step();
    checks++;
    if (busy !== 1'b0 || target_on !== 1'b0) begin
      errors++;
      $display("FAIL stale_rand_no_spawn: got busy=%0b on=%0b, want 0 0", busy, target_on);
    end
    rand_val = 4'd6;
    step();
    checks++;
    if (busy !== 1'b1 || target_x !== 10'd384 || target_y !== 10'd164) begin
      errors++;
      $display("FAIL spawn_cell6: got busy=%0b x=%0d y=%0d, want 1 384 164", busy, target_x, target_y);
    end
    video_on = 1'b0;
  endtask

  task automatic test_miss();
    rand_val = 4'd2;
    step();
    checks++;
    if (target_x !== 10'd384) begin
      errors++;
      $display("FAIL show_no_move: got x=%0d, want 384", target_x);
    end
    do_tick(); do_tick();
    checks++;
    if (misses !== 8'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL two_ticks_alive: got misses=%0d busy=%0b, want 0 1", misses, busy);
    end
    do_tick();
    checks++;
    if (misses !== 8'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL expire_miss: got misses=%0d busy=%0b, want 1 0", misses, busy);
    end
    do_tick();
    rand_val = 4'd5;
    step();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL respawn: got busy=%0b, want 1", busy);
    end
    do_tick(); do_tick();
    nanos = 28'd5;
    step();
    nanos = 28'd0; hit = 1'b1;
    step();
    hit = 1'b0;
    checks++;
    if (score !== 8'd2 || misses !== 8'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hit_beats_tick: got score=%0d misses=%0d busy=%0b, want 2 1 0", score, misses, busy);
    end
    do_tick();
  endtask

  task automatic test_corner();
    rand_val = 4'd15;
    step();
    checks++;
    if (target_x !== 10'd544 || target_y !== 10'd404) begin
      errors++;
      $display("FAIL spawn_cell15: got x=%0d y=%0d, want 544 404", target_x, target_y);
    end
    for (int i = 0; i < 253; i++) begin
      hit = 1'b1;
      step();
      hit = 1'b0;
      do_tick();
      rand_val = rand_val ^ 4'd1;
      step();
    end
    checks++;
    if (score !== 8'd255 || busy !== 1'b1) begin
      errors++;
      $display("FAIL score_255: got score=%0d busy=%0b, want 255 1", score, busy);
    end
    hit = 1'b1;
    step();
    hit = 1'b0;
    checks++;
    if (score !== 8'd255) begin
      errors++;
      $display("FAIL score_saturate: got %0d, want 255", score);
    end
    do_tick();
  endtask

  task automatic test_no_repeat();
    logic [9:0] exp_x;
`ifdef RAND_TARGET_NO_REPEAT_EN
    exp_x = 10'd384;
`else
    exp_x = 10'd224;
`endif
    rand_val = 4'd5;
    step();
    checks++;
    if (target_x !== 10'd224 || target_y !== 10'd164) begin
      errors++;
      $display("FAIL first_cell5: got x=%0d y=%0d, want 224 164", target_x, target_y);
    end
    do_tick(); do_tick(); do_tick();
    rand_val = 4'd9;
    step();
    do_tick();
    rand_val = 4'd5;
    step();
    checks++;
    if (busy !== 1'b1 || target_x !== exp_x || target_y !== 10'd164) begin
      errors++;
      $display("FAIL repeat_cell: got busy=%0b x=%0d y=%0d, want 1 %0d 164", busy, target_x, target_y, exp_x);
    end
  endtask

  task automatic test_reset_mid_show();
    hcount = target_x; vcount = target_y; video_on = 1'b1;
    step();
    checks++;
    if (target_on !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_on: got %0b, want 1", target_on);
    end
    reset = 1'b0;
    step();
    checks++;
    if (target_on !== 1'b0 || score !== 8'd0 || misses !== 8'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_show: got on=%0b score=%0d misses=%0d busy=%0b, want 0 0 0 0",
               target_on, score, misses, busy);
    end
    reset = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_spawn();
    test_hit();
    test_miss();
    test_corner();
    test_no_repeat();
    test_reset_mid_show();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rand_target_spawner.md
Name: rand_target_spawner

Overview:
- Consumes the 4-bit `rand` value and the 28-bit `nanos` count produced by the upstream random generator in the VGA design.
- Maps each new `rand` value to one cell of a 4x4 grid on a 640x480 screen and shows a square target there.
- Times the target's lifetime in `nanos` wrap events, then counts it as a hit or a miss.
- Drives a registered pixel-enable that the downstream colour mux ORs into the RGB output.

Parameters:
- CELL_W, 160, grid cell width in pixels (640/4)
- CELL_H, 120, grid cell height in pixels (480/4)
- TGT_SIZE, 32, target side length in pixels; must be < min(CELL_W, CELL_H)
- LIFETIME, 3, number of `tick` events a target stays visible (1..15)
- COOLDOWN, 1, number of `tick` events with no target after hit or expiry (0..15)

Ports:
- CLK  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-low reset (0 = reset)
- rand  input  4  upstream random value; row = rand[3:2], col = rand[1:0]
- nanos  input  28  upstream cycle counter; a wrap (value 0 after a nonzero value) is one `tick`
- hit  input  1  one-cycle player-hit strobe
- hcount  input  10  current pixel column from VGA sync
- vcount  input  10  current pixel row from VGA sync
- video_on  input  1  active display region
- target_on  output  1  current pixel lies inside the visible target (registered)
- target_x  output  10  left edge of the current target
- target_y  output  10  top edge of the current target
- score  output  8  hit counter, saturating at 255
- misses  output  8  expiry counter, saturating at 255
- busy  output  1  high in SHOW

Behaviour:
- Reset (reset==0 at a clock edge): state=WAIT; target_on=0; target_x=0; target_y=0; score=0; misses=0; busy=0; rand_q=rand; tick counter=0; nanos_q=0.
- Tick detect:
  - nanos_q is registered every cycle.
  - tick = (nanos==0) && (nanos_q!=0); one cycle long.
- New-value detect: new_rand = (rand != rand_q); rand_q updates every cycle.
- Position arithmetic (10-bit, unsigned, all operands fit):
  - target_x = col*CELL_W + (CELL_W-TGT_SIZE)/2
  - target_y = row*CELL_H + (CELL_H-TGT_SIZE)/2
  - Both are latched on WAIT->SHOW.
- FSM states WAIT, SHOW, COOL:
  - WAIT: on new_rand, latch position, clear tick counter, go to SHOW the next cycle. A `hit` in WAIT is ignored.
  - SHOW:
    - `hit` increments score, then go to COOL.
    - Otherwise each tick increments the counter; when the counter reaches LIFETIME, increment misses and go to COOL.
    - If `hit` and the final tick arrive in the same cycle, `hit` wins: score++ and misses unchanged.
    - new_rand in SHOW is ignored; the target does not move.
  - COOL: count ticks. When the count reaches COOLDOWN, go to WAIT. If COOLDOWN==0, go to WAIT the next cycle.
- After COOL, WAIT needs a fresh change of `rand`; a value that stayed unchanged since SHOW does not spawn a target.
- target_on is registered, one-cycle latency from hcount/vcount:
  - target_on = video_on && state==SHOW && target_x <= hcount < target_x+TGT_SIZE && target_y <= vcount < target_y+TGT_SIZE.
- Saturation: score and misses hold at 255; no wrap.
- Reset mid-SHOW: target_on=0 on the next cycle; counters cleared.

Optional Feature:
- Macro RAND_TARGET_NO_REPEAT_EN.
- Defined: if the new `rand` equals the cell of the previous target, the cell used is (rand+1) mod 16, so two consecutive targets never share a cell. The previous cell resets to 0.
- Undefined: the cell used is always `rand` directly.

Decomposition:
- Shared package vga_game_pkg holds:
  - the state encoding (WAIT=2'd0, SHOW=2'd1, COOL=2'd2)
  - H_ACTIVE=640 and V_ACTIVE=480
  - the GRID_DIM=4 constant
- Sub-module target_box_cmp: combinational point-in-square test (hcount, vcount, x, y -> inside), reusable for a future player cursor. The register stage stays in the parent.

Test Plan:
- Reset low 2 cycles, release -> all outputs 0, state WAIT; `rand` held constant 100 cycles -> no spawn, busy=0.
- `rand` 0->5 -> next cycle busy=1, target_x=224, target_y=164; hcount=224, vcount=164, video_on=1 -> target_on=1 one cycle later; hcount=256 -> target_on=0.
- Spawn, pulse `hit` -> score=1, state COOL; one tick -> WAIT; target_on stays 0 throughout COOL.
- Spawn, no hit, 3 ticks -> misses=1 on the third tick; on the same cycle as the third tick `hit`=1 in a second run -> score increments, misses unchanged.
- `rand`=15 -> target_x=544, target_y=404; score preloaded via 255 hits -> another hit keeps score=255.
- Defined RAND_TARGET_NO_REPEAT_EN: spawn at cell 5, expire, then `rand` changes 9->5 -> target uses cell 6 (target_x=384, target_y=164). Undefined: same stimulus -> cell 5.
